// File: rtl/matmul_pkg.sv
`default_nettype none
// ============================================================================
// Module  : matmul_pkg
// Brief   : Shared types, widths and the saturation helper for matmul_2x2_seq.
// Rev     : 1.0
// ============================================================================
package matmul_pkg;

  localparam int BIT_PREC_DEF = 8;

  typedef enum logic {
    IDLE = 1'b0,
    MAC  = 1'b1
  } state_t;

  function automatic int acc_width(input int bit_prec);
    return 2 * bit_prec + 1;
  endfunction

  // Clamps a sign-extended value to the signed range of a bit_prec-bit element.
  function automatic logic signed [63:0] sat_bitprec(input logic signed [63:0] v,
                                                     input int unsigned bit_prec);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bit_prec - 1)) - 64'sd1;
    lo = -(64'sd1 <<< (bit_prec - 1));
    if (v > hi) begin
      return hi;
    end else if (v < lo) begin
      return lo;
    end
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/matmul_2x2_seq_mac_sat.sv
`default_nettype none
// ============================================================================
// Module  : mac_sat
// Brief   : Combinational signed multiply-add with clamp to element width.
// Rev     : 1.0
// ============================================================================
module mac_sat
  import matmul_pkg::*;
#(
  parameter int BIT_PREC = BIT_PREC_DEF
) (
  input  logic signed [BIT_PREC-1:0]   a_i,
  input  logic signed [BIT_PREC-1:0]   b_i,
  input  logic signed [2*BIT_PREC:0]   acc_i,
  input  logic                         add_en_i,
  output logic signed [2*BIT_PREC:0]   sum_o,
  output logic signed [BIT_PREC-1:0]   sat_val_o,
  output logic                         sat_o
);

  localparam int PROD_W = 2 * BIT_PREC;
  localparam int ACC_W  = acc_width(BIT_PREC);

  logic signed [PROD_W-1:0] w_prod;
  logic signed [ACC_W-1:0]  w_prod_ext;
  logic signed [ACC_W-1:0]  w_addend;
  logic signed [ACC_W-1:0]  w_sum;
  logic signed [63:0]       w_sum_wide;
  logic signed [63:0]       w_clamped;

  assign w_prod     = a_i * b_i;
  assign w_prod_ext = {w_prod[PROD_W-1], w_prod};
  assign w_addend   = add_en_i ? acc_i : '0;
  assign w_sum      = w_addend + w_prod_ext;

  // Widen to the helper's fixed width so it stays independent of BIT_PREC.
  assign w_sum_wide = {{(64 - ACC_W){w_sum[ACC_W-1]}}, w_sum};
  assign w_clamped  = sat_bitprec(w_sum_wide, BIT_PREC);

  assign sum_o     = w_sum;
  assign sat_val_o = w_clamped[BIT_PREC-1:0];
  assign sat_o     = (w_clamped != w_sum_wide);

endmodule
`default_nettype wire

// File: rtl/matmul_2x2_seq.sv
`default_nettype none
// ============================================================================
// Module  : matmul_2x2_seq
// Brief   : Sequential 2x2 signed matrix multiplier, one MAC per cycle, 8 steps.
// Rev     : 1.0
// ============================================================================
module matmul_2x2_seq
  import matmul_pkg::*;
#(
  parameter int BIT_PREC = BIT_PREC_DEF
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start_i,
  input  logic signed [BIT_PREC-1:0] a_i [2][2],
  input  logic signed [BIT_PREC-1:0] b_i [2][2],
  output logic signed [BIT_PREC-1:0] c_o [2][2],
  output logic                       valid_o,
  output logic                       busy_o,
  output logic                       ovf_o
);

  localparam int ACC_W = acc_width(BIT_PREC);

  state_t                      state_q, state_d;
  logic [2:0]                  step_q, step_d;
  logic signed [BIT_PREC-1:0]  a_q [2][2];
  logic signed [BIT_PREC-1:0]  a_d [2][2];
  logic signed [BIT_PREC-1:0]  b_q [2][2];
  logic signed [BIT_PREC-1:0]  b_d [2][2];
  logic signed [BIT_PREC-1:0]  c_q [2][2];
  logic signed [BIT_PREC-1:0]  c_d [2][2];
  logic signed [ACC_W-1:0]     acc_q, acc_d;
  logic                        valid_q, valid_d;
  logic                        busy_q, busy_d;
  logic                        ovf_q, ovf_d;
  logic                        ovf_acc_q, ovf_acc_d;

  logic                        w_i, w_j, w_k;
  logic signed [ACC_W-1:0]     w_sum;
  logic signed [BIT_PREC-1:0]  w_sat_val;
  logic                        w_sat;

  // step = {i, j, k}: output row, output column, inner-product index.
  assign w_i = step_q[2];
  assign w_j = step_q[1];
  assign w_k = step_q[0];

  mac_sat #(
    .BIT_PREC (BIT_PREC)
  ) u_mac_sat (
    .a_i       (a_q[w_i][w_k]),
    .b_i       (b_q[w_k][w_j]),
    .acc_i     (acc_q),
    .add_en_i  (w_k),
    .sum_o     (w_sum),
    .sat_val_o (w_sat_val),
    .sat_o     (w_sat)
  );

  always_comb begin
    state_d   = state_q;
    step_d    = step_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    acc_d     = acc_q;
    valid_d   = 1'b0;
    busy_d    = busy_q;
    ovf_d     = ovf_q;
    ovf_acc_d = ovf_acc_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          state_d   = MAC;
          step_d    = 3'd0;
          a_d       = a_i;
          b_d       = b_i;
          busy_d    = 1'b1;
          ovf_acc_d = 1'b0;
        end
      end
      MAC: begin
        if (!w_k) begin
          acc_d = w_sum;
        end else begin
          c_d[w_i][w_j] = w_sat_val;
          ovf_acc_d     = ovf_acc_q | w_sat;
        end
        step_d = step_q + 3'd1;
        // The last step also writes C[1][1], so ovf must include its flag.
        if (step_q == 3'd7) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          valid_d = 1'b1;
          ovf_d   = ovf_acc_d;
        end
      end
      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      step_q    <= 3'd0;
      acc_q     <= '0;
      valid_q   <= 1'b0;
      busy_q    <= 1'b0;
      ovf_q     <= 1'b0;
      ovf_acc_q <= 1'b0;
      for (int r = 0; r < 2; r++) begin
        for (int c = 0; c < 2; c++) begin
          a_q[r][c] <= '0;
          b_q[r][c] <= '0;
          c_q[r][c] <= '0;
        end
      end
    end else begin
      state_q   <= state_d;
      step_q    <= step_d;
      acc_q     <= acc_d;
      valid_q   <= valid_d;
      busy_q    <= busy_d;
      ovf_q     <= ovf_d;
      ovf_acc_q <= ovf_acc_d;
      a_q       <= a_d;
      b_q       <= b_d;
      c_q       <= c_d;
    end
  end

  assign c_o     = c_q;
  assign valid_o = valid_q;
  assign busy_o  = busy_q;
  assign ovf_o   = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_matmul_2x2_seq.sv
`default_nettype none
// ============================================================================
// Module  : tb_matmul_2x2_seq
// Brief   : Directed, table-driven bench for matmul_2x2_seq.
// Rev     : 1.0
// ============================================================================
module tb_matmul_2x2_seq;

  logic              clk;
  logic              rst;
  logic              start;
  logic signed [7:0] a [2][2];
  logic signed [7:0] b [2][2];
  logic signed [7:0] c [2][2];
  logic              valid;
  logic              busy;
  logic              ovf;

  int n_checks;
  int n_errors;

  // Matrices are packed row-major: {m00, m01, m10, m11}.
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] c;
    logic        ovf;
  } vec_t;

  vec_t vecs [5];

  matmul_2x2_seq #(
    .BIT_PREC (8)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start_i (start),
    .a_i     (a),
    .b_i     (b),
    .c_o     (c),
    .valid_o (valid),
    .busy_o  (busy),
    .ovf_o   (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_ab(input logic [31:0] pa, input logic [31:0] pb);
    a[0][0] = pa[31:24]; a[0][1] = pa[23:16]; a[1][0] = pa[15:8]; a[1][1] = pa[7:0];
    b[0][0] = pb[31:24]; b[0][1] = pb[23:16]; b[1][0] = pb[15:8]; b[1][1] = pb[7:0];
  endtask

  function automatic logic [31:0] pack_c();
    return {c[0][0], c[0][1], c[1][0], c[1][1]};
  endfunction

  task automatic run_op(input string nm, input logic [31:0] pa, input logic [31:0] pb,
                        input logic [31:0] pc, input logic povf);
    int cyc;
    bit seen;
    @(negedge clk);
    set_ab(pa, pb);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    check({nm, " busy_after_accept"}, 32'(busy), 32'd1);
    cyc  = 0;
    seen = 1'b0;
    while (!seen && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
      if (valid) seen = 1'b1;
    end
    check({nm, " latency"}, cyc, 32'd8);
    check({nm, " C"}, pack_c(), pc);
    check({nm, " ovf"}, 32'(ovf), 32'(povf));
    check({nm, " busy_on_valid"}, 32'(busy), 32'd0);
    @(posedge clk);
    #1;
    check({nm, " valid_pulse"}, 32'(valid), 32'd0);
  endtask

  initial begin
    logic [31:0] c_seen;
    logic [31:0] sum2;
    int          nvalid;
    bit          seen;

    n_checks = 0;
    n_errors = 0;

    vecs[0] = '{a: {8'sd1, 8'sd2, 8'sd3, 8'sd4}, b: {8'sd1, 8'sd2, 8'sd3, 8'sd4},
                c: {8'sd7, 8'sd10, 8'sd15, 8'sd22}, ovf: 1'b0};
    vecs[1] = '{a: {-8'sd1, 8'sd2, 8'sd3, -8'sd4}, b: {8'sd5, -8'sd6, -8'sd7, 8'sd8},
                c: {-8'sd19, 8'sd22, 8'sd43, -8'sd50}, ovf: 1'b0};
    vecs[2] = '{a: {4{8'sd127}}, b: {4{8'sd127}}, c: {4{8'sd127}}, ovf: 1'b1};
    vecs[3] = '{a: {4{8'h80}}, b: {4{8'sd127}}, c: {4{8'h80}}, ovf: 1'b1};
    vecs[4] = '{a: {4{8'h80}}, b: {4{8'h80}}, c: {4{8'sd127}}, ovf: 1'b1};

    rst   = 1'b1;
    start = 1'b0;
    set_ab('0, '0);
    #2;
    check("reset C", pack_c(), 32'd0);
    check("reset valid", 32'(valid), 32'd0);
    check("reset busy", 32'(busy), 32'd0);
    check("reset ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int v = 0; v < 5; v++) begin
      run_op($sformatf("vec%0d", v), vecs[v].a, vecs[v].b, vecs[v].c, vecs[v].ovf);
      if (v == 0) begin
        sum2 = {8'(c[0][0] + c[0][0]), 8'(c[0][1] + c[0][1]),
                8'(c[1][0] + c[1][0]), 8'(c[1][1] + c[1][1])};
        check("chain C+C", sum2, {8'sd14, 8'sd20, 8'sd30, 8'sd44});
      end
    end

    // Restarts while busy and operand changes after accept must have no effect.
    @(negedge clk);
    set_ab(vecs[0].a, vecs[0].b);
    start = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    nvalid = 0;
    c_seen = '0;
    for (int cy = 1; cy <= 18; cy++) begin
      if (cy == 2) set_ab(vecs[2].a, vecs[4].b);
      start = (cy == 3 || cy == 8);
      @(posedge clk);
      #1;
      if (valid) begin
        nvalid++;
        c_seen = pack_c();
        check("busy_restart valid_cycle", cy, 32'd8);
      end
    end
    start = 1'b0;
    check("busy_restart valid_count", nvalid, 32'd1);
    check("busy_restart C", c_seen, vecs[0].c);
    check("busy_restart ovf", 32'(ovf), 32'd0);

    // Asynchronous reset four cycles into MAC discards the partial result.
    @(negedge clk);
    set_ab(vecs[1].a, vecs[1].b);
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("midrst C", pack_c(), 32'd0);
    check("midrst valid", 32'(valid), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (valid) seen = 1'b1;
    end
    check("midrst no_valid", 32'(seen), 32'd0);
    run_op("after_rst", vecs[1].a, vecs[1].b, vecs[1].c, vecs[1].ovf);

    // start held high: back-to-back results every 9 cycles.
    @(negedge clk);
    set_ab(vecs[0].a, vecs[0].b);
    start = 1'b1;
    @(posedge clk);
    #1;
    for (int cy = 1; cy <= 27; cy++) begin
      @(posedge clk);
      #1;
      check($sformatf("b2b valid c%0d", cy), 32'(valid), 32'((cy % 9) == 8));
      check($sformatf("b2b busy c%0d", cy), 32'(busy), 32'((cy % 9) != 8));
      if (valid) check($sformatf("b2b C c%0d", cy), pack_c(), vecs[0].c);
    end
    start = 1'b0;
    repeat (12) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
